// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared constants, state type and chunk-count helper for the word serializer
package word_serializer_pkg;

    localparam int SER_WORD_W  = 128;
    localparam int SER_CHUNK_W = 32;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    // Chunks needed for len bytes, plus one pad byte when pad is set and the block is not full.
    function automatic int ser_num_chunks(input int len, input bit pad,
                                          input int chunk_w, input int word_w);
        int bits;
        int n;
        bits = 8 * (len + ((pad && (len < word_w / 8)) ? 1 : 0));
        n    = (bits + chunk_w - 1) / chunk_w;
        if (n < 1) n = 1;
        if (n > word_w / chunk_w) n = word_w / chunk_w;
        return n;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - block-in / chunk-out handshake bundle for the word serializer
interface word_serializer_if import word_serializer_pkg::*; #(
    parameter int WORD_W  = SER_WORD_W,
    parameter int CHUNK_W = SER_CHUNK_W
);
    localparam int NUM_CHUNKS = WORD_W / CHUNK_W;
    localparam int LEN_W      = $clog2(WORD_W / 8 + 1);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic [LEN_W-1:0]   in_len;
    logic               out_valid;
    logic               out_ready;
    logic [CHUNK_W-1:0] out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_len, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/word_serializer_pad_mask.sv
// rtl/word_serializer_pad_mask.sv - byte mask, optional Ascon pad (ASCON_SER_PAD_EN) and chunk count
module ascon_pad_mask import word_serializer_pkg::*; #(
    parameter int WORD_W  = SER_WORD_W,
    parameter int CHUNK_W = SER_CHUNK_W,
    parameter int LEN_W   = $clog2(WORD_W / 8 + 1),
    parameter int IDX_W   = ((WORD_W / CHUNK_W) > 1) ? $clog2(WORD_W / CHUNK_W) : 1
) (
    input  logic [WORD_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    output logic [WORD_W-1:0] masked,
    output logic [IDX_W-1:0]  last_idx
);
    localparam int NBYTES = WORD_W / 8;
`ifdef ASCON_SER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic [LEN_W-1:0] len_eff;
    int               n;

    always_comb begin
        masked   = '0;
        len_eff  = (len > LEN_W'(NBYTES)) ? LEN_W'(NBYTES) : len;
        for (int i = 0; i < NBYTES; i++) begin
            if (i < int'(len_eff)) begin
                masked[8*i +: 8] = data[8*i +: 8];
            end else if (PAD && (i == int'(len_eff))) begin
                masked[8*i +: 8] = 8'h01;
            end
        end
        n        = ser_num_chunks(int'(len_eff), PAD, CHUNK_W, WORD_W);
        last_idx = IDX_W'(n - 1);
    end

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - length-aware block-to-chunk serializer; ASCON_SER_PAD_EN enables Ascon padding
module word_serializer import word_serializer_pkg::*; #(
    parameter int WORD_W  = SER_WORD_W,
    parameter int CHUNK_W = SER_CHUNK_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    word_serializer_if.slave  bus,
    output logic              busy
);
    localparam int NUM_CHUNKS = WORD_W / CHUNK_W;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    ser_state_t        state, state_nx;
    logic [WORD_W-1:0] shreg, shreg_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [IDX_W-1:0]  last_idx, last_idx_nx;

    logic [WORD_W-1:0] pm_data;
    logic [IDX_W-1:0]  pm_last;
    logic              shifting, hs_out, hs_last, load;

    ascon_pad_mask #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) u_pad_mask (
        .data     (bus.in_data),
        .len      (bus.in_len),
        .masked   (pm_data),
        .last_idx (pm_last)
    );

    assign shifting      = (state == SER_SHIFT);
    assign busy          = shifting;
    assign bus.out_valid = shifting;
    assign bus.out_data  = shreg[CHUNK_W-1:0];
    assign bus.out_idx   = idx;
    assign bus.out_last  = shifting && (idx == last_idx);

    assign hs_out       = shifting && bus.out_ready;
    assign hs_last      = hs_out && bus.out_last;
    assign bus.in_ready = !shifting || hs_last || clear;
    assign load         = bus.in_valid && bus.in_ready;

    // A load covers idle accept, chained accept on the last chunk and accept under clear.
    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        idx_nx      = idx;
        last_idx_nx = last_idx;
        if (load) begin
            state_nx    = SER_SHIFT;
            shreg_nx    = pm_data;
            idx_nx      = '0;
            last_idx_nx = pm_last;
        end else if (clear || hs_last) begin
            state_nx    = SER_IDLE;
            shreg_nx    = '0;
            idx_nx      = '0;
            last_idx_nx = '0;
        end else if (hs_out) begin
            shreg_nx = shreg >> CHUNK_W;
            idx_nx   = IDX_W'(idx + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SER_IDLE;
            shreg    <= '0;
            idx      <= '0;
            last_idx <= '0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            idx      <= idx_nx;
            last_idx <= last_idx_nx;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - randomized bench for word_serializer against a byte-level block model
module tb_word_serializer;
    localparam int WORD_W  = 128;
    localparam int CHUNK_W = 32;
`ifdef ASCON_SER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        int          idx;
        bit          last;
    } chunk_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   rdy_seen;
    int   vld_seen;

    chunk_t      exp_q[$];
    logic [31:0] got[$];

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    word_serializer_if #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) bus();

    word_serializer #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Expected chunks of a block, built byte by byte from the length rules.
    function automatic void model_load(logic [127:0] d, int len);
        logic [7:0] b[16];
        int le, n, padb;
        chunk_t c;
        le   = (len > 16) ? 16 : len;
        padb = (PAD && le < 16) ? 1 : 0;
        for (int i = 0; i < 16; i++) b[i] = (i < le) ? d[8*i +: 8] : 8'h00;
        if (padb == 1) b[le] = 8'h01;
        n = (8 * (le + padb) + 31) / 32;
        if (n < 1) n = 1;
        if (n > 4) n = 4;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            c.d    = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            c.idx  = k;
            c.last = (k == n - 1);
            exp_q.push_back(c);
        end
    endfunction

    task automatic step(input bit iv, input logic [127:0] d, input int len,
                        input bit ordy, input bit clr);
        bit     exp_rdy;
        chunk_t f;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_len    = 5'(len);
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        exp_rdy = (exp_q.size() == 0) || (ordy && exp_q[0].last) || clr;
        chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
        chk("busy", 128'(busy), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", 128'(bus.out_data), 128'(exp_q[0].d));
            chk("out_idx", 128'(bus.out_idx), 128'(exp_q[0].idx));
            chk("out_last", 128'(bus.out_last), 128'(exp_q[0].last));
        end
        if (bus.in_ready) rdy_seen++;
        if (bus.out_valid) vld_seen++;
        if (bus.out_valid && ordy) got.push_back(bus.out_data);
        if (clr) begin
            exp_q.delete();
            if (iv) model_load(d, len);
        end else if (exp_q.size() == 0) begin
            if (iv) model_load(d, len);
        end else if (ordy) begin
            f = exp_q.pop_front();
            if (f.last && iv) model_load(d, len);
        end
    endtask

    task automatic run_block(input string nm, input int len,
                             input logic [31:0] e[4], input int cnt);
        got.delete();
        step(1'b1, BLK_A, len, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 0, 1'b1, 1'b0);
        chk({nm, "_count"}, 128'(got.size()), 128'(cnt));
        for (int i = 0; i < cnt && i < got.size(); i++)
            chk({nm, "_chunk"}, 128'(got[i]), 128'(e[i]));
    endtask

    initial begin
        logic [31:0] e_full[4];
        logic [31:0] e_b[4];
        e_full = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        e_b    = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data", 128'(bus.out_data), 128'(0));
        chk("rst_out_idx", 128'(bus.out_idx), 128'(0));
        chk("rst_out_last", 128'(bus.out_last), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        reset_n = 1'b1;

        run_block("full", 16, e_full, 4);
        run_block("len20", 20, e_full, 4);
`ifdef ASCON_SER_PAD_EN
        run_block("len5", 5, '{32'hCCDDEEFF, 32'h000001BB, 32'h0, 32'h0}, 2);
        run_block("len4", 4, '{32'hCCDDEEFF, 32'h00000001, 32'h0, 32'h0}, 2);
        run_block("len0", 0, '{32'h00000001, 32'h0, 32'h0, 32'h0}, 1);
`else
        run_block("len5", 5, '{32'hCCDDEEFF, 32'h000000BB, 32'h0, 32'h0}, 2);
        run_block("len4", 4, '{32'hCCDDEEFF, 32'h0, 32'h0, 32'h0}, 1);
        run_block("len0", 0, '{32'h00000000, 32'h0, 32'h0, 32'h0}, 1);
`endif

        // Back-to-back: in_valid held, second block must chain with no gap.
        got.delete();
        step(1'b1, BLK_A, 16, 1'b1, 1'b0);
        rdy_seen = 0;
        vld_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, BLK_B, 16, 1'b1, 1'b0);
        chk("b2b_ready_pulses", 128'(rdy_seen), 128'(1));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 0, 1'b1, 1'b0);
        chk("b2b_valid_cycles", 128'(vld_seen), 128'(8));
        chk("b2b_count", 128'(got.size()), 128'(8));
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("b2b_chunk", 128'(got[i]), 128'((i < 4) ? e_full[i] : e_b[i-4]));
        step(1'b0, '0, 0, 1'b1, 1'b0);

        // Backpressure.
        got.delete();
        step(1'b1, BLK_A, 16, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 0, (i % 3) == 0, 1'b0);
        chk("bp_count", 128'(got.size()), 128'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("bp_chunk", 128'(got[i]), 128'(e_full[i]));

        // Abort after chunk 1 is presented.
        step(1'b1, BLK_A, 16, 1'b1, 1'b0);
        step(1'b0, '0, 0, 1'b1, 1'b0);
        chk("abort_idx_before", 128'(bus.out_idx), 128'(0));
        step(1'b0, '0, 0, 1'b0, 1'b1);
        chk("abort_idx_at", 128'(bus.out_idx), 128'(1));
        step(1'b0, '0, 0, 1'b0, 1'b0);
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));

        // Asynchronous reset mid-block.
        step(1'b1, BLK_A, 16, 1'b1, 1'b0);
        step(1'b0, '0, 0, 1'b1, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_out_data", 128'(bus.out_data), 128'(0));
        chk("arst_out_idx", 128'(bus.out_idx), 128'(0));
        chk("arst_out_last", 128'(bus.out_last), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        exp_q.delete();
        #1 reset_n = 1'b1;
        got.delete();
        step(1'b1, BLK_A, 16, 1'b1, 1'b0);
        step(1'b0, '0, 0, 1'b0, 1'b0);
        chk("post_rst_idx", 128'(bus.out_idx), 128'(0));
        chk("post_rst_data", 128'(bus.out_data), 128'(32'hCCDDEEFF));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 2) != 0,
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 20),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
